pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the MIPS datapath. It is the successor to the fixed 6-bit PC incrementer and holds the PC register. Each cycle it selects the next PC from sequential, branch, jump, call and return sources. It includes a stall hold, a sticky wrap flag, and an optional return-address stack (RAS). It sits between the control unit / branch comparator and the instruction-memory address port.

## Interface
Parameters:
- `PC_W`, default 32: PC width in bits. Legal range 8..32.
- `RESET_VEC`, default 32'h0040_0000: PC value loaded on reset. Truncated to `PC_W` bits.
- `RAS_DEPTH`, default 4: number of RAS entries, power of two, 2..16. Only used with `PC_RAS_EN`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hold all state; every request in the same cycle is ignored.
- `branch_taken` in 1: take a PC-relative branch.
- `branch_off` in 16: signed word offset.
- `jump` in 1: take an absolute jump.
- `jump_target` in 26: word index of the jump target.
- `call` in 1: jump-and-link; pushes the return address to the RAS.
- `ret` in 1: return; pops the RAS into the PC.
- `pc` out `PC_W`: registered current PC.
- `pc_plus4` out `PC_W`: combinational `pc + 4`, modulo 2^`PC_W`.
- `pc_wrap` out 1: sticky flag; the sequential increment carried out of bit `PC_W-1`.
- `ras_empty` out 1: RAS holds no entries.
- `ras_full` out 1: RAS holds `RAS_DEPTH` entries.
- `ras_err` out 1: sticky flag; RAS overflow or underflow has occurred.

## Operation
Next-PC sources:
- Sequential: `seq = pc + 4`. Carry-out is the carry of this add.
- Branch: `br = pc_plus4 + (sext(branch_off) << 2)`, modulo 2^`PC_W`.
- Jump: `jt = (pc_plus4 & ~M) | ({jump_target, 2'b00} & M)`.
  - `M` masks the low `min(PC_W, 28)` bits.

Priority (highest first):
1. `reset`: `pc` = `RESET_VEC`, `pc_wrap` = 0, RAS emptied, `ras_err` = 0.
2. `stall`: `pc`, `pc_wrap` and the RAS all hold.
3. `ret`.
4. `call`, or `jump`: load `jt`. `call` with `jump` is the same as `call`.
5. `branch_taken`: load `br`.
6. Otherwise load `seq`.

`pc_wrap`:
- Set only when `seq` is the selected source and the add carries out.
- Once set, it clears only on reset.

RAS (circular buffer, top pointer plus count):
- `call`: push `pc_plus4`, then load `jt`.
- `call` when full: overwrite the oldest entry; the count stays `RAS_DEPTH`; set `ras_err`.
- `ret` when not empty: load the top entry into `pc`, then pop.
- `ret` when empty: load `seq`; set `ras_err`. `pc_wrap` is updated as for a sequential step.
- `call` and `ret` in the same cycle: `ret` wins and `call` is ignored; there is no push.

## Timing
- One-cycle latency: requests sampled at edge N appear on `pc` after edge N.
- `pc_plus4` follows `pc` combinationally within the same cycle.
- Reset values: `pc` = `RESET_VEC`; `pc_wrap` = 0; `ras_empty` = 1; `ras_full` = 0; `ras_err` = 0.
- Reset asserted mid-sequence takes effect at the next edge. Pending RAS contents are discarded.
- `ras_empty`, `ras_full` and `ras_err` are registered and update on the same edge as the push or pop.
- Requests have no handshake. The requester must hold a request that arrives during `stall` until `stall` is low.

## Configuration
`PC_RAS_EN`:
- Defined: the RAS is built as described above.
- Undefined:
  - No RAS storage is built.
  - `call` behaves exactly like `jump`.
  - `ret` is ignored, and the source falls through to `jump` / `branch_taken` / sequential.
  - `ras_empty` is tied to 1; `ras_full` and `ras_err` are tied to 0.

## Test plan
All scenarios use `PC_W`=32 and `RESET_VEC`=0x0040_0000 unless stated otherwise.
- Reset, then three idle cycles -> `pc` = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; `pc_wrap` = 0.
- At `pc`=0x00400010, `branch_taken`=1 with `branch_off`=0xFFFC -> next `pc` = 0x00400004. With `jump`=1 in the same cycle and `jump_target`=0x0100040 -> next `pc` = 0x00400100 (jump wins).
- `stall`=1 for 2 cycles with `branch_taken`=1 at `pc`=0x00400008 -> `pc` holds 0x00400008 for 2 cycles. After `stall` falls, the branch is taken next cycle.
- `PC_RAS_EN` defined, `RAS_DEPTH`=4:
  - `call` at 0x00400008 with target 0x0100040 -> `pc` = 0x00400100; a following `ret` -> `pc` = 0x0040000C.
  - 5 nested calls -> `ras_full`=1, `ras_err`=1.
  - 4 returns restore the last 4 return addresses in LIFO order.
  - A 5th `ret` -> `ras_empty`=1 and `pc` advances by 4.
- `PC_W`=8, `RESET_VEC`=0xF8, idle -> `pc` = 0xF8, 0xFC, 0x00, 0x04. `pc_wrap` rises with `pc`=0x00 and stays 1 until `reset`.
- `PC_RAS_EN` undefined: `call` -> `pc` = `jt`; `ret` alone -> `pc` advances by 4; `ras_empty`=1 throughout.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: selects next PC from sequential/branch/jump/call/return
// sources, with stall hold, sticky wrap flag and an optional RAS (`PC_RAS_EN`).
module pc_unit #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] RESET_VEC = 32'h0040_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [15:0]     branch_off,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            pc_wrap,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  logic [PC_W-1:0] r_pc;
  logic            r_wrap;

  logic [PC_W:0]   w_seq_sum;
  logic            w_carry;
  logic [PC_W-1:0] w_br;
  logic [PC_W-1:0] w_jt;
  logic [PC_W-1:0] w_next_pc;
  logic            w_sel_seq;
  logic            w_push;
  logic            w_pop;
  logic            w_err_set;

  assign w_seq_sum = {1'b0, r_pc} + (PC_W+1)'(4);
  assign pc_plus4  = w_seq_sum[PC_W-1:0];
  assign w_carry   = w_seq_sum[PC_W];
  assign w_br      = pc_plus4 + PC_W'({{16{branch_off[15]}}, branch_off, 2'b00});
  // Upper 4 bits come from pc_plus4 only when PC_W exceeds the 28-bit jump field.
  assign w_jt      = PC_W'({4'(32'(pc_plus4) >> 28), jump_target, 2'b00});

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [PW-1:0]   w_top_inc;

  assign w_top_inc = r_top + PW'(1);
  assign ras_empty = (r_cnt == '0);
  assign ras_full  = (r_cnt == CW'(RAS_DEPTH));
  assign ras_err   = r_err;

  always_comb begin
    w_next_pc = pc_plus4;
    w_sel_seq = 1'b1;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (ret) begin
      if (!ras_empty) begin
        w_next_pc = r_ras[r_top];
        w_sel_seq = 1'b0;
        w_pop     = 1'b1;
      end else begin
        w_err_set = 1'b1;
      end
    end else if (call) begin
      w_next_pc = w_jt;
      w_sel_seq = 1'b0;
      w_push    = 1'b1;
      w_err_set = ras_full;
    end else if (jump) begin
      w_next_pc = w_jt;
      w_sel_seq = 1'b0;
    end else if (branch_taken) begin
      w_next_pc = w_br;
      w_sel_seq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_top <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (!stall) begin
      if (w_push) begin
        // When full the write lands on the oldest slot; count saturates.
        r_top <= w_top_inc;
        if (!ras_full) r_cnt <= r_cnt + CW'(1);
      end else if (w_pop) begin
        r_top <= r_top - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push) r_ras[w_top_inc] <= pc_plus4;
  end
`else
  logic w_unused_ras;
  assign w_unused_ras = ret | (RAS_DEPTH == 0);
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_err      = 1'b0;

  always_comb begin
    w_next_pc = pc_plus4;
    w_sel_seq = 1'b1;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (call || jump) begin
      w_next_pc = w_jt;
      w_sel_seq = 1'b0;
    end else if (branch_taken) begin
      w_next_pc = w_br;
      w_sel_seq = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_VEC[PC_W-1:0];
      r_wrap <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (w_sel_seq && w_carry) r_wrap <= 1'b1;
    end
  end

  assign pc      = r_pc;
  assign pc_wrap = r_wrap;

endmodule
